// File: rtl/rotate_sq_pkg.sv
// Shared constants for the rotating-square display: segment codes and mode encodings.
package rotate_sq_pkg;

  localparam logic [7:0] SEG_UPPER = 8'h9C;
  localparam logic [7:0] SEG_LOWER = 8'hA3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] MODE_ROT = 2'd0;
  localparam logic [1:0] MODE_BNC = 2'd1;
  localparam logic [1:0] MODE_TRL = 2'd2;
  localparam logic [1:0] MODE_BLK = 2'd3;

endpackage

// File: rtl/seg_scan_mux.sv
// Generic N-digit 7-seg time multiplexer: walks the digits and registers the
// active-low select together with that digit's segment pattern.
module seg_scan_mux
  import rotate_sq_pkg::*;
#(
  parameter int unsigned N_DIGITS = 6,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DIGITS-1:0][7:0] pattern,
  output logic [7:0]               seg_out,
  output logic [N_DIGITS-1:0]      sel_out
);

  localparam int unsigned DW = $clog2(N_DIGITS);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] IDX_LAST  = DW'(N_DIGITS - 1);

  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] scan_idx;

  // Select and segments are loaded on the same edge so a digit never shows its neighbour's code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg_out  <= SEG_BLANK;
      sel_out  <= '1;
    end else begin
      sel_out <= ~(N_DIGITS'(1) << scan_idx);
      seg_out <= pattern[scan_idx];
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + DW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/rotate_sq_scan.sv
// Square travelling around the perimeter of an N-digit 7-seg row, with rotate,
// bounce, trail and blank modes, driving the display through seg_scan_mux.
module rotate_sq_scan
  import rotate_sq_pkg::*;
#(
  parameter int unsigned N_DIGITS = 6,
  parameter int unsigned STEP_DIV = 25_000_000,
  parameter int unsigned SCAN_DIV = 50_000,
  localparam int unsigned PW = $clog2(2 * N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cw,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [7:0]          seg_out,
  output logic [N_DIGITS-1:0] sel_out,
  output logic [PW-1:0]       pos,
  output logic                step
);

  localparam int unsigned NP = 2 * N_DIGITS;
  localparam int unsigned CW = $clog2(STEP_DIV);
  localparam int unsigned DW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] POS_LAST  = PW'(NP - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] step_cnt;
  logic          dir_up;
  logic          dir_nxt;
  logic [1:0]    last_mode;
  logic          step_hit;
  logic [PW-1:0] pos_inc;
  logic [PW-1:0] pos_dec;
  logic [PW-1:0] pos_nxt;
  logic [PW-1:0] prev;
  logic [N_DIGITS-1:0][7:0] pattern;

  // Top row runs left to right, bottom row right to left.
  function automatic logic [DW-1:0] digit_of(input logic [PW-1:0] p);
    int unsigned pi;
    pi = 32'(p);
    return (pi < N_DIGITS) ? DW'(N_DIGITS - 1 - pi) : DW'(pi - N_DIGITS);
  endfunction

  function automatic logic [7:0] code_of(input logic [PW-1:0] p);
    return (32'(p) < N_DIGITS) ? SEG_UPPER : SEG_LOWER;
  endfunction

  assign step_hit = en && (step_cnt == STEP_LAST);

  always_comb begin
    pos_inc = (pos == POS_LAST) ? '0 : pos + PW'(1);
    pos_dec = (pos == '0) ? POS_LAST : pos - PW'(1);
  end

  // Next position; bounce reloads its direction from cw on the first step after entering the mode.
  always_comb begin
    pos_nxt = cw ? pos_inc : pos_dec;
    dir_nxt = dir_up;
    if (mode == MODE_BNC) begin
      dir_nxt = (last_mode != MODE_BNC) ? cw : dir_up;
      if (dir_nxt) begin
        if (pos == POS_LAST) begin
          dir_nxt = 1'b0;
          pos_nxt = pos_dec;
        end else begin
          pos_nxt = pos_inc;
        end
      end else begin
        if (pos == '0) begin
          dir_nxt = 1'b1;
          pos_nxt = pos_inc;
        end else begin
          pos_nxt = pos_dec;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt  <= '0;
      pos       <= '0;
      dir_up    <= 1'b1;
      step      <= 1'b0;
      last_mode <= MODE_ROT;
    end else begin
      step <= step_hit;
      if (en) begin
        if (step_hit) begin
          step_cnt  <= '0;
          pos       <= pos_nxt;
          dir_up    <= dir_nxt;
          last_mode <= mode;
        end else begin
          step_cnt <= step_cnt + CW'(1);
        end
      end
    end
  end

  // Per-digit frame; in trail mode a shared digit shows the AND of both codes.
  always_comb begin
    prev    = cw ? pos_dec : pos_inc;
    pattern = {N_DIGITS{SEG_BLANK}};
    if (mode != MODE_BLK) begin
      pattern[digit_of(pos)] = code_of(pos);
      if (mode == MODE_TRL) begin
        pattern[digit_of(prev)] = pattern[digit_of(prev)] & code_of(prev);
      end
    end
  end

  seg_scan_mux #(
    .N_DIGITS (N_DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .pattern (pattern),
    .seg_out (seg_out),
    .sel_out (sel_out)
  );

endmodule

// File: tb/tb_rotate_sq_scan.sv
// Directed self-checking bench for rotate_sq_scan with N_DIGITS=4, STEP_DIV=4, SCAN_DIV=2.
module tb_rotate_sq_scan;
  import rotate_sq_pkg::*;

  logic       clk;
  logic       rst;
  logic       cw;
  logic       en;
  logic [1:0] mode;
  logic [7:0] seg_out;
  logic [3:0] sel_out;
  logic [2:0] pos;
  logic       step;

  int total = 0;
  int bad   = 0;
  int cyc;

  rotate_sq_scan #(
    .N_DIGITS (4),
    .STEP_DIV (4),
    .SCAN_DIV (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cw      (cw),
    .en      (en),
    .mode    (mode),
    .seg_out (seg_out),
    .sel_out (sel_out),
    .pos     (pos),
    .step    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < 40);
    if (step !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL step_timeout observed=%0d cycles expected=step pulse", n);
    end
  endtask

  // Waits for the given digit to be selected and checks its segment code.
  task automatic check_digit(input string tag, input int d, input logic [7:0] exp);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << d);
    n = 0;
    do begin
      tick();
      n++;
    end while (sel_out !== tgt && n < 20);
    if (sel_out !== tgt) begin
      total++;
      bad++;
      $error("FAIL %s_sel observed=%h expected=%h", tag, sel_out, tgt);
    end else begin
      check(tag, 32'(seg_out), 32'(exp));
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    cw   = 1'b1;
    mode = MODE_ROT;
    repeat (3) tick();
    check("rst_seg", 32'(seg_out), 32'h0FF);
    check("rst_sel", 32'(sel_out), 32'hF);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_step", 32'(step), 32'd0);

    // Frozen at pos 0: upper square on the leftmost digit
    rst = 1'b0;
    check_digit("t1_d3", 3, 8'h9C);
    check_digit("t1_d0", 0, 8'hFF);

    // Clockwise rotation, one step every 4 clocks, 7 wraps to 0
    en = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      wait_step(cyc);
      check($sformatf("t2_pos%0d", i), 32'(pos), 32'(i % 8));
      check($sformatf("t2_cyc%0d", i), 32'(cyc), 32'd4);
    end
    en = 1'b0;
    check_digit("t2_p5_d0", 0, 8'hFF);
    check_digit("t2_p5_d1", 1, 8'hA3);
    check_digit("t2_p5_d2", 2, 8'hFF);
    check_digit("t2_p5_d3", 3, 8'hFF);

    // Counter-clockwise wrap 0 -> 7 -> 6, then cw toggled mid-count
    en = 1'b1;
    wait_step(cyc); check("t3_pos6", 32'(pos), 32'd6);
    wait_step(cyc); check("t3_pos7", 32'(pos), 32'd7);
    wait_step(cyc); check("t3_pos0", 32'(pos), 32'd0);
    cw = 1'b0;
    wait_step(cyc); check("t3_ccw7", 32'(pos), 32'd7);
    wait_step(cyc); check("t3_ccw6", 32'(pos), 32'd6);
    tick();
    tick();
    cw = 1'b1;
    wait_step(cyc);
    check("t3_tog_pos", 32'(pos), 32'd7);
    check("t3_tog_cyc", 32'(cyc), 32'd2);

    // Freeze with step_cnt at 2, then resume: step after 2 more clocks
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t4_hold_pos%0d", i), 32'(pos), 32'd7);
      check($sformatf("t4_hold_step%0d", i), 32'(step), 32'd0);
    end
    en = 1'b1;
    wait_step(cyc);
    check("t4_resume_cyc", 32'(cyc), 32'd2);
    check("t4_resume_pos", 32'(pos), 32'd0);
    tick();
    check("t4_pulse_width", 32'(step), 32'd0);

    // Bounce entered at pos 6 with cw=1
    cw = 1'b0;
    wait_step(cyc); check("t5_pre7", 32'(pos), 32'd7);
    wait_step(cyc); check("t5_pre6", 32'(pos), 32'd6);
    mode = MODE_BNC;
    cw   = 1'b1;
    wait_step(cyc); check("t5_b7", 32'(pos), 32'd7);
    wait_step(cyc); check("t5_b6", 32'(pos), 32'd6);
    for (int p = 5; p >= 0; p--) begin
      wait_step(cyc);
      check($sformatf("t5_down%0d", p), 32'(pos), 32'(p));
    end
    cw = 1'b0;
    wait_step(cyc); check("t5_bounce1", 32'(pos), 32'd1);
    wait_step(cyc); check("t5_up2", 32'(pos), 32'd2);

    // Trail: pos 4 shares digit 0 with prev 3
    mode = MODE_TRL;
    cw   = 1'b1;
    wait_step(cyc); check("t6_pos3", 32'(pos), 32'd3);
    wait_step(cyc); check("t6_pos4", 32'(pos), 32'd4);
    en = 1'b0;
    check_digit("t6_p4_d0", 0, 8'h80);
    check_digit("t6_p4_d1", 1, 8'hFF);
    check_digit("t6_p4_d3", 3, 8'hFF);
    en = 1'b1;
    wait_step(cyc); check("t6_pos5", 32'(pos), 32'd5);
    en = 1'b0;
    check_digit("t6_p5_d0", 0, 8'hA3);
    check_digit("t6_p5_d1", 1, 8'hA3);
    check_digit("t6_p5_d2", 2, 8'hFF);
    cw = 1'b0;
    check_digit("t6_ccw_d2", 2, 8'hA3);
    check_digit("t6_ccw_d0", 0, 8'hFF);

    // Blank mode keeps stepping but shows nothing
    mode = MODE_BLK;
    check_digit("t7_d1", 1, 8'hFF);
    check_digit("t7_d2", 2, 8'hFF);
    cw = 1'b1;
    en = 1'b1;
    wait_step(cyc); check("t7_pos6", 32'(pos), 32'd6);

    // Asynchronous reset mid-step
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t8_seg", 32'(seg_out), 32'h0FF);
    check("t8_sel", 32'(sel_out), 32'hF);
    check("t8_pos", 32'(pos), 32'd0);
    check("t8_step", 32'(step), 32'd0);
    tick();
    rst  = 1'b0;
    mode = MODE_ROT;
    wait_step(cyc);
    check("t8_first_cyc", 32'(cyc), 32'd4);
    check("t8_first_pos", 32'(pos), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
